// File: rtl/mem_lsu_pkg.sv
// Shared definitions for the MEM-stage load/store unit: funct3 codes, FSM state
// type and the byte-enable helper used when issuing a data-memory request.
package mem_lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } lsu_state_t;

  // Half accesses look only at addr[1]; anything wider than a half is a full word.
  function automatic logic [3:0] be_for(input logic [2:0] funct3, input logic [1:0] addr);
    logic [3:0] be;
    case (funct3)
      F3_B, F3_BU: be = 4'b0001 << addr;
      F3_H, F3_HU: be = 4'b0011 << {addr[1], 1'b0};
      default:     be = 4'b1111;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/mem_lsu_stage_load_align.sv
// Combinational load-data lane select with sign/zero extension (RV32I load funct3).
module lsu_load_align
  import mem_lsu_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] rdata_i,
  output logic [31:0] data_o
);

  logic [7:0]  lane [4];
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign lane[gi] = rdata_i[8*gi +: 8];
    end
  endgenerate

  assign byte_sel = lane[addr_lo_i];
  assign half_sel = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];

  always_comb begin
    case (funct3_i)
      F3_B:    data_o = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   data_o = {24'd0, byte_sel};
      F3_H:    data_o = {{16{half_sel[15]}}, half_sel};
      F3_HU:   data_o = {16'd0, half_sel};
      default: data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/mem_lsu_stage.sv
// MEM-stage load/store unit: issues data-memory accesses, stalls upstream while one is
// outstanding, registers results toward MEM/WB. MISALIGN_TRAP_EN adds misaligned-access trapping.
module mem_lsu_stage
  import mem_lsu_pkg::*;
#(
  parameter int TIMEOUT_CYC = 255,
  parameter int CNT_W       = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic        in_load,
  input  logic        in_store,
  input  logic [2:0]  in_funct3,
  input  logic [31:0] in_addr,
  input  logic [31:0] in_wdata,
  input  logic        in_we,
  input  logic [4:0]  in_rd,
  input  logic [31:0] in_pc,
  output logic        stall,
  output logic        out_valid,
  output logic        mem_we,
  output logic [4:0]  mem_rd,
  output logic [31:0] mem_pc,
  output logic [31:0] mem_ALU_out,
  output logic [31:0] mem_DataB,
  output logic        bus_err,
  output logic        dm_req,
  output logic        dm_wen,
  output logic [3:0]  dm_be,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wdata,
  input  logic        dm_ready,
  input  logic        dm_rvalid,
  input  logic [31:0] dm_rdata
`ifdef MISALIGN_TRAP_EN
  ,
  output logic        misalign
`endif
);

  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYC - 1);

  lsu_state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Operands latched for the duration of the access
  logic        is_load_q, is_load_d;
  logic        we_l_q, we_l_d;
  logic [4:0]  rd_l_q, rd_l_d;
  logic [31:0] pc_l_q, pc_l_d;
  logic [31:0] addr_l_q, addr_l_d;
  logic [2:0]  f3_q, f3_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] data_q, data_d;
  logic        err_q, err_d;

  // MEM/WB-facing output registers
  logic        valid_q, valid_d;
  logic        we_q, we_d;
  logic [4:0]  rd_q, rd_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] alu_q, alu_d;
  logic [31:0] datab_q, datab_d;
  logic        berr_q, berr_d;
`ifdef MISALIGN_TRAP_EN
  logic        mis_q, mis_d;
`endif

  logic        memop, mis_op, access, to_hit, st_only;
  logic [31:0] aligned;
  logic [31:0] wdata_rep;

  assign memop   = in_valid & (in_load | in_store);
  assign st_only = in_store & ~in_load;

`ifdef MISALIGN_TRAP_EN
  assign mis_op = memop & (((in_funct3[1:0] == 2'b01) & in_addr[0]) |
                           ((in_funct3 == F3_W) & (in_addr[1:0] != 2'b00)));
`else
  assign mis_op = 1'b0;
`endif

  assign access = memop & ~mis_op;
  // Held in reset, the stage must not freeze the pipeline on a stale instruction.
  assign stall  = ~rst & access & (state_q != ST_DONE);
  assign to_hit = (TIMEOUT_CYC != 0) && (cnt_q == TO_LAST);

  always_comb begin
    case (in_funct3)
      F3_B:    wdata_rep = {4{in_wdata[7:0]}};
      F3_H:    wdata_rep = {2{in_wdata[15:0]}};
      default: wdata_rep = in_wdata;
    endcase
  end

  lsu_load_align u_align (
    .funct3_i  (f3_q),
    .addr_lo_i (addr_l_q[1:0]),
    .rdata_i   (dm_rdata),
    .data_o    (aligned)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    is_load_d = is_load_q;
    we_l_d    = we_l_q;
    rd_l_d    = rd_l_q;
    pc_l_d    = pc_l_q;
    addr_l_d  = addr_l_q;
    f3_d      = f3_q;
    be_d      = be_q;
    wdata_d   = wdata_q;
    data_d    = data_q;
    err_d     = err_q;
    case (state_q)
      ST_IDLE: begin
        if (access) begin
          is_load_d = in_load;
          we_l_d    = in_we;
          rd_l_d    = in_rd;
          pc_l_d    = in_pc;
          addr_l_d  = in_addr;
          f3_d      = in_funct3;
          be_d      = (st_only & in_funct3[2]) ? 4'b1111 : be_for(in_funct3, in_addr[1:0]);
          wdata_d   = wdata_rep;
          data_d    = 32'd0;
          err_d     = 1'b0;
          cnt_d     = '0;
          state_d   = ST_REQ;
        end
      end
      ST_REQ: begin
        cnt_d = cnt_q + 1'b1;
        if (dm_ready) begin
          if (!is_load_q) begin
            state_d = ST_DONE;
          end else if (dm_rvalid) begin
            data_d  = aligned;
            state_d = ST_DONE;
          end else begin
            state_d = ST_WAIT;
          end
        end else if (to_hit) begin
          err_d   = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q + 1'b1;
        if (dm_rvalid) begin
          data_d  = aligned;
          state_d = ST_DONE;
        end else if (to_hit) begin
          err_d   = 1'b1;
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    valid_d = 1'b0;
    we_d    = 1'b0;
    rd_d    = 5'd0;
    pc_d    = 32'd0;
    alu_d   = 32'd0;
    datab_d = 32'd0;
    berr_d  = 1'b0;
`ifdef MISALIGN_TRAP_EN
    mis_d   = 1'b0;
`endif
    if (state_q == ST_DONE) begin
      valid_d = 1'b1;
      we_d    = is_load_q & we_l_q & ~err_q;
      rd_d    = rd_l_q;
      pc_d    = pc_l_q;
      alu_d   = addr_l_q;
      datab_d = (is_load_q & ~err_q) ? data_q : 32'd0;
      berr_d  = err_q;
    end else if (state_q == ST_IDLE && !stall) begin
      // Non-memory instruction (or trapped misaligned access) passes straight through.
      valid_d = in_valid;
      we_d    = in_valid & in_we & ~mis_op;
      rd_d    = in_rd;
      pc_d    = in_pc;
      alu_d   = in_addr;
`ifdef MISALIGN_TRAP_EN
      mis_d   = mis_op;
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      is_load_q <= 1'b0;
      we_l_q    <= 1'b0;
      rd_l_q    <= 5'd0;
      pc_l_q    <= 32'd0;
      addr_l_q  <= 32'd0;
      f3_q      <= 3'd0;
      be_q      <= 4'd0;
      wdata_q   <= 32'd0;
      data_q    <= 32'd0;
      err_q     <= 1'b0;
      valid_q   <= 1'b0;
      we_q      <= 1'b0;
      rd_q      <= 5'd0;
      pc_q      <= 32'd0;
      alu_q     <= 32'd0;
      datab_q   <= 32'd0;
      berr_q    <= 1'b0;
`ifdef MISALIGN_TRAP_EN
      mis_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      is_load_q <= is_load_d;
      we_l_q    <= we_l_d;
      rd_l_q    <= rd_l_d;
      pc_l_q    <= pc_l_d;
      addr_l_q  <= addr_l_d;
      f3_q      <= f3_d;
      be_q      <= be_d;
      wdata_q   <= wdata_d;
      data_q    <= data_d;
      err_q     <= err_d;
      valid_q   <= valid_d;
      we_q      <= we_d;
      rd_q      <= rd_d;
      pc_q      <= pc_d;
      alu_q     <= alu_d;
      datab_q   <= datab_d;
      berr_q    <= berr_d;
`ifdef MISALIGN_TRAP_EN
      mis_q     <= mis_d;
`endif
    end
  end

  // Bus outputs derive from the state register so reset drops the request at once.
  assign dm_req   = (state_q == ST_REQ);
  assign dm_wen   = dm_req & ~is_load_q;
  assign dm_be    = dm_req ? be_q : 4'd0;
  assign dm_addr  = dm_req ? {addr_l_q[31:2], 2'b00} : 32'd0;
  assign dm_wdata = dm_req ? wdata_q : 32'd0;

  assign out_valid   = valid_q;
  assign mem_we      = we_q;
  assign mem_rd      = rd_q;
  assign mem_pc      = pc_q;
  assign mem_ALU_out = alu_q;
  assign mem_DataB   = datab_q;
  assign bus_err     = berr_q;
`ifdef MISALIGN_TRAP_EN
  assign misalign    = mis_q;
`endif

endmodule
